// File: rtl/bus_drvr_fifo_if.sv
// Device/bus-side signal bundle for one bus_drvr_fifo instance.
// The slave modport is the queue itself; the master modport is the device plus the bus reader.
interface bus_drvr_fifo_if #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
);
  localparam int CW = $clog2(depth + 1);

  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               full;
  logic               almost_full;
  logic               pop;
  logic [pckg_sz-1:0] D_pop;
  logic               pndng;
  logic [CW-1:0]      count;
  logic               ovf;
  logic               udf;
  logic               flag_clr;

  modport slave (
    input  push, D_push, pop, flag_clr,
    output full, almost_full, D_pop, pndng, count, ovf, udf
  );

  modport master (
    output push, D_push, pop, flag_clr,
    input  full, almost_full, D_pop, pndng, count, ovf, udf
  );
endinterface

// File: rtl/bus_drvr_fifo.sv
// Per-device transmit queue with a first-word-fall-through head for the bus arbiter.
// Circular buffer of any depth >= 2, sticky overflow/underflow flags, and an asynchronous active-low reset.
module bus_drvr_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int af_lvl  = depth - 2
) (
  input  logic           clk,
  input  logic           reset,
  bus_drvr_fifo_if.slave bus
);
  localparam int CW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);

  logic [pckg_sz-1:0] mem_q [depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;

  logic is_empty, is_full, do_pop, do_push;

  // Pointers wrap at depth-1 explicitly, so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(depth));
  assign do_pop   = bus.pop && !is_empty;
  // A pop in the same cycle frees the head slot, so a push on a full queue still lands.
  assign do_push  = bus.push && (!is_full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A set event outranks flag_clr in the same cycle.
    ovf_d = (ovf_q && !bus.flag_clr) || (bus.push && !do_push);
    udf_d = (udf_q && !bus.flag_clr) || (bus.pop && is_empty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never reset; stale entries are hidden by the D_pop gate below.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.D_push;
  end

  assign bus.pndng       = !is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (count_q >= CW'(af_lvl));
  assign bus.count       = count_q;
  assign bus.ovf         = ovf_q;
  assign bus.udf         = udf_q;
  assign bus.D_pop       = is_empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: tb/tb_bus_drvr_fifo.sv
// Directed bench for bus_drvr_fifo (depth 8, 16-bit packets); every expected value is written out by hand.
module tb_bus_drvr_fifo;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  bus_drvr_fifo_if #(.pckg_sz(16), .depth(8)) bus ();

  bus_drvr_fifo #(.pckg_sz(16), .depth(8), .af_lvl(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".pndng"}, 32'(bus.pndng),       32'd0);
    chk({tag, ".dpop"},  32'(bus.D_pop),       32'h0);
    chk({tag, ".count"}, 32'(bus.count),       32'd0);
    chk({tag, ".full"},  32'(bus.full),        32'd0);
    chk({tag, ".af"},    32'(bus.almost_full), 32'd0);
    chk({tag, ".ovf"},   32'(bus.ovf),         32'd0);
    chk({tag, ".udf"},   32'(bus.udf),         32'd0);
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    reset        = 1'b0;
    bus.push     = 1'b0;
    bus.D_push   = 16'h0;
    bus.pop      = 1'b0;
    bus.flag_clr = 1'b0;

    // Reset then idle
    #2;
    chk_idle("in_rst");
    tick();
    #2;
    reset = 1'b1;
    tick();
    chk_idle("idle");

    // Fill with A001..A008
    for (int i = 1; i <= 8; i++) begin
      bus.push   = 1'b1;
      bus.D_push = 16'hA000 + 16'(i);
      tick();
      chk("fill.count", 32'(bus.count), 32'(i));
      chk("fill.full", 32'(bus.full), (i == 8) ? 32'd1 : 32'd0);
      chk("fill.af", 32'(bus.almost_full), (i >= 6) ? 32'd1 : 32'd0);
      chk("fill.head", 32'(bus.D_pop), 32'hA001);
    end
    bus.push = 1'b0;

    // Drain, checking order
    for (int i = 1; i <= 8; i++) begin
      chk("drain.head", 32'(bus.D_pop), 32'hA000 + 32'(i));
      bus.pop = 1'b1;
      tick();
      chk("drain.count", 32'(bus.count), 32'(8 - i));
    end
    bus.pop = 1'b0;
    chk("drain.pndng", 32'(bus.pndng), 32'd0);
    chk("drain.dpop", 32'(bus.D_pop), 32'h0);
    chk("drain.udf", 32'(bus.udf), 32'd0);

    // Refill
    for (int i = 1; i <= 8; i++) begin
      bus.push   = 1'b1;
      bus.D_push = 16'hA000 + 16'(i);
      tick();
    end
    chk("refill.full", 32'(bus.full), 32'd1);

    // Overflow on full
    bus.D_push = 16'hBEEF;
    tick();
    bus.push = 1'b0;
    chk("ovf.count", 32'(bus.count), 32'd8);
    chk("ovf.flag", 32'(bus.ovf), 32'd1);
    chk("ovf.head", 32'(bus.D_pop), 32'hA001);
    bus.flag_clr = 1'b1;
    tick();
    bus.flag_clr = 1'b0;
    chk("ovf.clr", 32'(bus.ovf), 32'd0);

    // Push+pop while full
    bus.push   = 1'b1;
    bus.pop    = 1'b1;
    bus.D_push = 16'hC0DE;
    tick();
    bus.push = 1'b0;
    chk("pp.count", 32'(bus.count), 32'd8);
    chk("pp.head", 32'(bus.D_pop), 32'hA002);
    chk("pp.ovf", 32'(bus.ovf), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      chk("pp.out", 32'(bus.D_pop), 32'hA001 + 32'(i));
      tick();
    end
    bus.pop = 1'b0;
    chk("pp.last", 32'(bus.D_pop), 32'hC0DE);
    chk("pp.cnt1", 32'(bus.count), 32'd1);
    chk("pp.ovf2", 32'(bus.ovf), 32'd0);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    chk("pp.empty", 32'(bus.count), 32'd0);

    // Underflow
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    chk("udf.flag", 32'(bus.udf), 32'd1);
    chk("udf.count", 32'(bus.count), 32'd0);
    bus.flag_clr = 1'b1;
    tick();
    bus.flag_clr = 1'b0;
    chk("udf.clr", 32'(bus.udf), 32'd0);

    // Push+pop on empty: push lands, pop ignored
    bus.push   = 1'b1;
    bus.pop    = 1'b1;
    bus.D_push = 16'h1234;
    tick();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    chk("pe.udf", 32'(bus.udf), 32'd1);
    chk("pe.count", 32'(bus.count), 32'd1);
    chk("pe.dpop", 32'(bus.D_pop), 32'h1234);

    // Set beats clear
    bus.pop = 1'b1;
    tick();
    bus.flag_clr = 1'b1;
    tick();
    bus.pop      = 1'b0;
    bus.flag_clr = 1'b0;
    chk("prio.udf", 32'(bus.udf), 32'd1);
    chk("prio.count", 32'(bus.count), 32'd0);

    // Mid-cycle reset with packets queued
    for (int i = 1; i <= 5; i++) begin
      bus.push   = 1'b1;
      bus.D_push = 16'h7000 + 16'(i);
      tick();
    end
    bus.push = 1'b0;
    chk("pre.count", 32'(bus.count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("arst");
    bus.push   = 1'b1;
    bus.D_push = 16'h9999;
    tick();
    bus.push = 1'b0;
    chk("arst.hold", 32'(bus.count), 32'd0);
    #2;
    reset = 1'b1;
    bus.push   = 1'b1;
    bus.D_push = 16'h5555;
    tick();
    bus.push = 1'b0;
    chk("post.count", 32'(bus.count), 32'd1);
    chk("post.dpop", 32'(bus.D_pop), 32'h5555);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    chk("post.pndng", 32'(bus.pndng), 32'd0);
    chk("post.dpop0", 32'(bus.D_pop), 32'h0);
    chk("post.udf", 32'(bus.udf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bus_drvr_fifo.md
# bus_drvr_fifo

Per-device transmit queue that sits directly upstream of the bus generator/arbiter (`bs_gnrtr_n_rbtr`). One instance feeds each drive port of the bus. The device side writes packets at its own pace. The bus side sees a first-word-fall-through interface: `pndng` flags a waiting packet, `D_pop` holds the head packet, and a `pop` pulse consumes it. Occupancy, almost-full, and sticky overflow/underflow flags let the device throttle and let the bench detect misuse.

## Interface
- `pckg_sz`, default 16: packet width in bits; the block treats the data as opaque.
- `depth`, default 8: number of entries; any value ≥ 2 is legal, and power-of-two is not required.
- `af_lvl`, default `depth-2`: `almost_full` asserts when `count` ≥ `af_lvl`; legal range 1..`depth`.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low; 0 clears all state immediately.
- `push`  in  1: device write strobe; samples `D_push` on the rising edge.
- `D_push`  in  `pckg_sz`: packet from the device.
- `full`  out  1: `count == depth`.
- `almost_full`  out  1: `count >= af_lvl`.
- `pop`  in  1: bus read strobe; consumes the head entry on the rising edge.
- `D_pop`  out  `pckg_sz`: head entry when `pndng` = 1, otherwise all zeros.
- `pndng`  out  1: `count != 0`.
- `count`  out  `$clog2(depth+1)`: current occupancy.
- `ovf`  out  1: sticky; set by a dropped write.
- `udf`  out  1: sticky; set by a pop while empty.
- `flag_clr`  in  1: synchronous clear of `ovf` and `udf`.

## Operation
- Storage is a circular buffer of `depth` entries, with write pointer `wr_ptr`, read pointer `rd_ptr` and register `count`.
- Each pointer wraps from `depth-1` to 0. No power-of-two masking is used.
- All outputs are combinational decodes of registered state: `pndng`, `full`, `almost_full`, `D_pop = pndng ? mem[rd_ptr] : 0`. They carry no extra pipeline.
- Accepted write: `mem[wr_ptr] <= D_push`, `wr_ptr` advances, `count` increments.
- Accepted pop: `rd_ptr` advances, `count` decrements. Memory contents are not cleared.
- Push while full, no pop: the write is dropped, `ovf` is set, and pointers, `count` and memory are unchanged.
- Push and pop together while full: both are accepted. The head is consumed, the new packet is written into the freed slot, and `count` stays at `depth`. `ovf` is not set.
- Pop while empty, no push: ignored, `udf` is set.
- Push and pop together while empty: the push is accepted (`count` becomes 1), the pop is ignored and `udf` is set. Write data never bypasses to `D_pop` in the same cycle.
- Push and pop together, 0 < `count` < `depth`: both are accepted and `count` is unchanged.
- Flag priority: a set event in the same cycle as `flag_clr` wins, so the flag stays 1.
- Reset (`reset` = 0, any time, including mid-burst) clears `wr_ptr`, `rd_ptr` and `count`, and drops all queued packets.
  - Memory contents are not reset; they are masked by `D_pop` gating.
  - During and after reset: `pndng` = 0, `D_pop` = 0, `full` = 0, `count` = 0, `ovf` = 0, `udf` = 0, and `almost_full` = 0.
- Deassertion of reset is synchronized by the system. The block accepts its first `push` on the first rising edge with `reset` = 1.

## Timing
- Write-to-visible latency is 1 cycle: a push sampled at edge N gives `pndng` = 1 and valid `D_pop` after edge N.
- `pop` at edge N: `D_pop` shows the next entry, or zeros if the queue is now empty, after edge N.
- The bus may pop back-to-back every cycle. The device may push every cycle.
- Sustained one-push-one-pop per cycle gives one packet per cycle of throughput, with no bubbles.
- `full`, `almost_full` and `count` update in the same cycle as the `count` register. `ovf`/`udf` are registered and appear 1 cycle after the offending edge.
- `pop` is meaningful only while `pndng` = 1. The bus generator must not sample `D_pop` while `pndng` = 0.

## Test plan
- Reset then idle, `depth`=8, `pckg_sz`=16 -> `pndng`=0, `D_pop`=16'h0000, `count`=0, `full`=0, `ovf`=`udf`=0.
- Push 16'hA001..16'hA008 on consecutive cycles, then pop 8 times -> `count` rises to 8 with `full`=1 and `almost_full`=1 from `count`=6. `D_pop` sequence is A001..A008 in order, then `pndng`=0 and `D_pop`=0.
- With the queue full, push 16'hBEEF with no pop -> `count` stays 8, `ovf`=1 next cycle, and the head is still A001. Then pulse `flag_clr` -> `ovf`=0.
- With the queue full, push 16'hC0DE and pop together -> `count`=8 and `D_pop`=A002. After 7 more pops, the last packet out is C0DE, and `ovf` remains 0.
- Pop on an empty queue, then push 16'h1234 and pop together on an empty queue -> `udf`=1, `count`=1 and `D_pop`=16'h1234.
- Push 5 packets, assert `reset`=0 asynchronously mid-cycle, release, push 16'h5555 -> all outputs go to 0 immediately on reset. After the push, `count`=1, `D_pop`=16'h5555, and no stale packet appears.
